// File: rtl/stream_master_gen_if.sv
// Valid/ready stream bundle carrying a payload word and an end-of-burst marker.
interface stream_master_gen_if #(
    parameter int unsigned DATA_W = 32
);
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              last;
    logic              ready;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/stream_master_gen.sv
// Stream traffic generator: emits an incrementing payload as continuous, burst+gap
// or single-burst traffic on a valid/ready bus, with fully registered outputs.
module stream_master_gen #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned BURST_LEN = 8,
    parameter int unsigned GAP_LEN   = 4,
    parameter int unsigned START_VAL = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [1:0]                 mode,
    input  logic                       restart,
    stream_master_gen_if.master        bus,
    output logic                       done,
    output logic [31:0]                beat_cnt
);

    typedef enum logic [1:0] {StIdle, StSend, StGap, StDone} state_e;

    localparam logic [DATA_W-1:0] StartVal = DATA_W'(START_VAL);
    localparam logic [15:0]       LastIdx  = 16'(BURST_LEN - 1);
    localparam logic [15:0]       GapLast  = 16'(GAP_LEN - 1);

    state_e            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [DATA_W-1:0] payload_q, payload_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              done_q, done_d;
    logic [31:0]       beat_cnt_q, beat_cnt_d;
    logic [15:0]       burst_q, burst_d;
    logic [15:0]       gap_q, gap_d;
    logic              rst_pend_q, rst_pend_d;

    logic              xfer;
    logic              restart_now;
    logic [DATA_W-1:0] next_val;
    logic [15:0]       next_burst;
    logic [DATA_W-1:0] idle_val;

    assign xfer        = valid_q & bus.ready;
    // A restart seen while a beat is held is deferred to that beat's transfer edge.
    assign restart_now = rst_pend_q | restart;
    assign next_val    = restart_now ? StartVal : data_q + DATA_W'(1);
    assign next_burst  = (restart_now || last_q) ? 16'd0 : burst_q + 16'd1;
    assign idle_val    = restart ? StartVal : payload_q;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        payload_d  = payload_q;
        data_d     = data_q;
        valid_d    = valid_q;
        last_d     = last_q;
        done_d     = done_q;
        beat_cnt_d = beat_cnt_q;
        burst_d    = burst_q;
        gap_d      = gap_q;
        rst_pend_d = rst_pend_q;

        case (state_q)
            StIdle: begin
                if (restart) begin
                    payload_d = StartVal;
                    burst_d   = 16'd0;
                end
                if (en && mode != 2'd3) begin
                    state_d = StSend;
                    mode_d  = mode;
                    data_d  = idle_val;
                    valid_d = 1'b1;
                    last_d  = (LastIdx == 16'd0);
                end
            end
            StSend: begin
                if (restart) begin
                    rst_pend_d = 1'b1;
                end
                if (xfer) begin
                    beat_cnt_d = beat_cnt_q + 32'd1;
                    payload_d  = next_val;
                    burst_d    = next_burst;
                    rst_pend_d = 1'b0;
                    valid_d    = 1'b0;
                    last_d     = 1'b0;
                    if (!en) begin
                        state_d = StIdle;
                        burst_d = 16'd0;
                    end else if (last_q && mode_q == 2'd2) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        burst_d = 16'd0;
                    end else if (last_q && mode_q == 2'd1 && GAP_LEN != 0) begin
                        state_d = StGap;
                        gap_d   = 16'd0;
                    end else begin
                        data_d  = next_val;
                        valid_d = 1'b1;
                        last_d  = (next_burst == LastIdx);
                    end
                end
            end
            StGap: begin
                if (restart) begin
                    payload_d = StartVal;
                    burst_d   = 16'd0;
                end
                if (!en) begin
                    state_d = StIdle;
                    gap_d   = 16'd0;
                end else if (gap_q == GapLast) begin
                    gap_d = 16'd0;
                    // Mode is re-sampled here; a request to hold idle parks in IDLE.
                    if (mode == 2'd3) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StSend;
                        mode_d  = mode;
                        data_d  = idle_val;
                        valid_d = 1'b1;
                        last_d  = (LastIdx == 16'd0);
                    end
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            StDone: begin
                if (restart) begin
                    payload_d = StartVal;
                    burst_d   = 16'd0;
                end
                if (!en) begin
                    state_d = StIdle;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
                last_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            mode_q     <= 2'd0;
            payload_q  <= StartVal;
            data_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
            beat_cnt_q <= 32'd0;
            burst_q    <= 16'd0;
            gap_q      <= 16'd0;
            rst_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            payload_q  <= payload_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            done_q     <= done_d;
            beat_cnt_q <= beat_cnt_d;
            burst_q    <= burst_d;
            gap_q      <= gap_d;
            rst_pend_q <= rst_pend_d;
        end
    end

    assign bus.data  = data_q;
    assign bus.valid = valid_q;
    assign bus.last  = last_q;
    assign done      = done_q;
    assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_stream_master_gen.sv
// Scoreboard bench for stream_master_gen: expected beats are queued as stimulus is
// applied and retired by negedge monitors on each transfer.
module tb_stream_master_gen;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic        en_a, restart_a, done_a;
    logic [1:0]  mode_a;
    logic [31:0] beat_cnt_a;
    logic        en_b, restart_b, done_b;
    logic [1:0]  mode_b;
    logic [31:0] beat_cnt_b;

    int n_checks = 0;
    int n_errors = 0;

    beat_t qa[$];
    beat_t qb[$];
    int    gap_q[$];

    stream_master_gen_if #(.DATA_W(32)) bus_a ();
    stream_master_gen_if #(.DATA_W(4))  bus_b ();

    stream_master_gen #(
        .DATA_W(32), .BURST_LEN(4), .GAP_LEN(2), .START_VAL(1)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .mode(mode_a), .restart(restart_a),
        .bus(bus_a), .done(done_a), .beat_cnt(beat_cnt_a)
    );

    stream_master_gen #(
        .DATA_W(4), .BURST_LEN(4), .GAP_LEN(2), .START_VAL(1)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .mode(mode_b), .restart(restart_b),
        .bus(bus_b), .done(done_b), .beat_cnt(beat_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [31:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        qa.push_back(b);
    endtask

    task automatic push_b(input logic [31:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        qb.push_back(b);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_drain_a(input int budget, input bit toggle);
        int n = 0;
        while (qa.size() != 0 && n < budget) begin
            if (toggle) bus_a.ready = !bus_a.ready;
            tick();
            n++;
        end
        check_eq("drain_a", 64'(qa.size()), 64'd0);
    endtask

    task automatic wait_drain_b(input int budget);
        int n = 0;
        while (qb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check_eq("drain_b", 64'(qb.size()), 64'd0);
    endtask

    // Retire one held beat of A after en has been dropped; the generator must then idle.
    task automatic drain_one_a(input logic [31:0] d, input logic l);
        push_a(d, l);
        bus_a.ready = 1'b1;
        tick();
        bus_a.ready = 1'b0;
        check_eq("idle_after_drain_a", 64'(bus_a.valid), 64'd0);
        check_eq("queue_after_drain_a", 64'(qa.size()), 64'd0);
    endtask

    // Monitor A: scoreboard, hold-stability while stalled, and gap length after last.
    initial begin
        bit          hold = 1'b0;
        logic [31:0] hold_data = '0;
        logic        hold_last = 1'b0;
        bit          gap_on = 1'b0;
        int          gap_run = 0;
        beat_t       e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold   = 1'b0;
                gap_on = 1'b0;
            end else begin
                if (hold) begin
                    check_eq("hold_valid_a", 64'(bus_a.valid), 64'd1);
                    check_eq("hold_data_a", 64'(bus_a.data), 64'(hold_data));
                    check_eq("hold_last_a", 64'(bus_a.last), 64'(hold_last));
                end
                if (gap_on) begin
                    if (!bus_a.valid) gap_run++;
                    else begin
                        gap_q.push_back(gap_run);
                        gap_on = 1'b0;
                    end
                end
                if (bus_a.valid && bus_a.ready) begin
                    if (qa.size() == 0) begin
                        check_eq("spurious_beat_a", 64'(qa.size()), 64'd1);
                    end else begin
                        e = qa.pop_front();
                        check_eq("data_a", 64'(bus_a.data), 64'(e.data));
                        check_eq("last_a", 64'(bus_a.last), 64'(e.last));
                    end
                    if (bus_a.last) begin
                        gap_on  = 1'b1;
                        gap_run = 0;
                    end
                end
                hold      = bus_a.valid && !bus_a.ready;
                hold_data = bus_a.data;
                hold_last = bus_a.last;
            end
        end
    end

    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus_b.valid && bus_b.ready) begin
                if (qb.size() == 0) begin
                    check_eq("spurious_beat_b", 64'(qb.size()), 64'd1);
                end else begin
                    e = qb.pop_front();
                    check_eq("data_b", 64'(bus_b.data), 64'(e.data));
                    check_eq("last_b", 64'(bus_b.last), 64'(e.last));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        en_a = 1'b0; mode_a = 2'd0; restart_a = 1'b0; bus_a.ready = 1'b0;
        en_b = 1'b0; mode_b = 2'd0; restart_b = 1'b0; bus_b.ready = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        check_eq("rst_valid_a", 64'(bus_a.valid), 64'd0);
        check_eq("rst_last_a", 64'(bus_a.last), 64'd0);
        check_eq("rst_done_a", 64'(done_a), 64'd0);
        check_eq("rst_data_a", 64'(bus_a.data), 64'd0);
        check_eq("rst_beat_cnt_a", 64'(beat_cnt_a), 64'd0);
        check_eq("rst_valid_b", 64'(bus_b.valid), 64'd0);
        tick();
        tick();

        // Burst + gap at full ready
        rst_n = 1'b1;
        en_a = 1'b1; mode_a = 2'd1; bus_a.ready = 1'b1;
        gap_q.delete();
        for (int i = 1; i <= 8; i++) push_a(32'(i), (i % 4) == 0);
        wait_drain_a(100, 1'b0);
        check_eq("gap_beat_cnt", 64'(beat_cnt_a), 64'd8);
        check_eq("gap_len", 64'((gap_q.size() > 0) ? gap_q[0] : 999), 64'd2);
        en_a = 1'b0;
        tick();
        check_eq("gap_en_low_valid", 64'(bus_a.valid), 64'd0);
        bus_a.ready = 1'b0;

        // Continuous mode with ready toggling every cycle
        do_reset();
        en_a = 1'b1; mode_a = 2'd0;
        for (int i = 1; i <= 8; i++) push_a(32'(i), (i % 4) == 0);
        wait_drain_a(100, 1'b1);
        check_eq("cont_beat_cnt", 64'(beat_cnt_a), 64'd8);
        bus_a.ready = 1'b0;
        en_a = 1'b0;
        drain_one_a(32'd9, 1'b0);
        check_eq("cont_beat_cnt_final", 64'(beat_cnt_a), 64'd9);

        // Single burst, done handshake, then a second burst continuing the payload
        do_reset();
        en_a = 1'b1; mode_a = 2'd2; bus_a.ready = 1'b1;
        for (int i = 1; i <= 4; i++) push_a(32'(i), i == 4);
        wait_drain_a(50, 1'b0);
        check_eq("single_done", 64'(done_a), 64'd1);
        check_eq("single_valid", 64'(bus_a.valid), 64'd0);
        en_a = 1'b0;
        tick();
        check_eq("single_done_clear", 64'(done_a), 64'd0);
        en_a = 1'b1;
        for (int i = 5; i <= 8; i++) push_a(32'(i), i == 8);
        wait_drain_a(50, 1'b0);
        check_eq("single_done_2", 64'(done_a), 64'd1);
        check_eq("single_beat_cnt", 64'(beat_cnt_a), 64'd8);
        en_a = 1'b0;
        bus_a.ready = 1'b0;
        tick();

        // Narrow payload wraps modulo 16
        do_reset();
        en_b = 1'b1; mode_b = 2'd0; bus_b.ready = 1'b1;
        for (int i = 1; i <= 17; i++) push_b(32'(i % 16), (i % 4) == 0);
        wait_drain_b(100);
        bus_b.ready = 1'b0;
        en_b = 1'b0;
        push_b(32'd2, 1'b0);
        bus_b.ready = 1'b1;
        tick();
        bus_b.ready = 1'b0;
        check_eq("wrap_idle_b", 64'(bus_b.valid), 64'd0);
        check_eq("wrap_beat_cnt_b", 64'(beat_cnt_b), 64'd18);
        check_eq("wrap_queue_b", 64'(qb.size()), 64'd0);

        // en dropped while stalled, then restart while a beat is held
        do_reset();
        en_a = 1'b1; mode_a = 2'd0; bus_a.ready = 1'b0;
        tick();
        en_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("en_low_hold_valid", 64'(bus_a.valid), 64'd1);
            check_eq("en_low_hold_data", 64'(bus_a.data), 64'd1);
        end
        drain_one_a(32'd1, 1'b0);
        en_a = 1'b1;
        tick();
        push_a(32'd2, 1'b0); push_a(32'd3, 1'b0); push_a(32'd4, 1'b0); push_a(32'd5, 1'b1);
        push_a(32'd6, 1'b0);
        push_a(32'd1, 1'b0); push_a(32'd2, 1'b0); push_a(32'd3, 1'b0); push_a(32'd4, 1'b1);
        bus_a.ready = 1'b1;
        repeat (4) tick();
        bus_a.ready = 1'b0;
        check_eq("restart_held_data", 64'(bus_a.data), 64'd6);
        restart_a = 1'b1;
        tick();
        restart_a = 1'b0;
        check_eq("restart_held_keep", 64'(bus_a.data), 64'd6);
        bus_a.ready = 1'b1;
        wait_drain_a(50, 1'b0);
        bus_a.ready = 1'b0;
        en_a = 1'b0;
        drain_one_a(32'd5, 1'b0);
        check_eq("restart_beat_cnt", 64'(beat_cnt_a), 64'd11);

        // Asynchronous reset mid-burst while stalled
        do_reset();
        en_a = 1'b1; mode_a = 2'd0; bus_a.ready = 1'b1;
        push_a(32'd1, 1'b0); push_a(32'd2, 1'b0); push_a(32'd3, 1'b0);
        wait_drain_a(20, 1'b0);
        bus_a.ready = 1'b0;
        check_eq("pre_rst_beat_cnt", 64'(beat_cnt_a), 64'd3);
        tick();
        check_eq("pre_rst_valid", 64'(bus_a.valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_valid", 64'(bus_a.valid), 64'd0);
        check_eq("async_rst_data", 64'(bus_a.data), 64'd0);
        check_eq("async_rst_beat_cnt", 64'(beat_cnt_a), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check_eq("post_rst_valid", 64'(bus_a.valid), 64'd1);
        check_eq("post_rst_data", 64'(bus_a.data), 64'd1);
        en_a = 1'b0;
        drain_one_a(32'd1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/stream_master_gen.md
STREAM_MASTER_GEN -- requirements
Module: stream_master_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of data payload.
REQ-002 SHALL have parameter BURST_LEN, default 8, beats per burst (range 1..65535).
REQ-003 SHALL have parameter GAP_LEN, default 4, idle cycles between bursts in mode 1 (range 0..65535).
REQ-004 SHALL have parameter START_VAL, default 1, first payload value after reset or restart.
REQ-005 SHALL have ports: clk  in  1  sole clock, rising edge; rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports: en  in  1  generator enable; mode  in  2  0=continuous, 1=burst+gap, 2=single burst, 3=hold idle; restart  in  1  one-cycle pulse that reloads payload to START_VAL.
REQ-007 SHALL have ports: data  out  DATA_W  payload; valid  out  1  payload valid; last  out  1  final beat of burst; ready  in  1  sink accept.
REQ-008 SHALL have ports: done  out  1  single burst complete; beat_cnt  out  32  total accepted beats since reset.

Function
REQ-009 Transfer SHALL occur exactly on rising clk edge with valid=1 and ready=1.
REQ-010 Once valid=1, valid, data and last SHALL remain stable until the transfer edge; valid SHALL never depend combinationally on ready.
REQ-011 FSM states SHALL be IDLE, SEND, GAP, DONE; all outputs registered.
REQ-012 IDLE: valid=0; if en=1 and mode!=3, next edge -> SEND with valid=1, data=current payload, mode latched.
REQ-013 SEND: on each transfer payload SHALL increment by 1, modulo 2^DATA_W (all-ones wraps to 0); burst beat counter increments.
REQ-014 last SHALL be 1 on beat BURST_LEN of each burst (every beat if BURST_LEN=1), 0 otherwise.
REQ-015 On transfer of last beat: mode 0 -> stay SEND, next beat presented in next cycle (zero bubble); mode 1 -> GAP if GAP_LEN>0 else stay SEND; mode 2 -> DONE.
REQ-016 Mode 0 and mode 1 SHALL present a new beat in the cycle after every non-last transfer (one beat per cycle at full ready).
REQ-017 GAP: valid=0 for exactly GAP_LEN cycles, then SEND with mode re-latched.
REQ-018 DONE: valid=0, done=1; stays until en=0, then IDLE with done=0.
REQ-019 mode input SHALL be sampled only in IDLE and at GAP->SEND; changes mid-burst ignored until then.
REQ-020 en=0 in SEND SHALL NOT drop valid; current beat held until transfer, then IDLE (burst counter cleared; payload continues from next value).
REQ-021 en=0 in GAP SHALL go IDLE next edge.
REQ-022 restart=1 SHALL set payload to START_VAL and clear burst counter: in IDLE/GAP/DONE immediately; in SEND applied on the next transfer edge (the held beat completes unchanged), taking priority over increment.
REQ-023 beat_cnt SHALL increment by 1 per transfer, wrap at 2^32, unaffected by restart.

Reset
REQ-024 rst_n=0 SHALL asynchronously force state IDLE, valid=0, last=0, done=0, data=0, beat_cnt=0, payload register=START_VAL, burst/gap counters=0.
REQ-025 Release of rst_n SHALL take effect at the first rising clk edge after deassertion; no transfer SHALL occur on that edge.
REQ-026 Reset asserted mid-burst SHALL abort the burst with valid low immediately, without waiting for ready.

Verification (BURST_LEN=4, GAP_LEN=2, START_VAL=1, DATA_W=32 unless stated)
REQ-027 mode 1, en=1, ready=1 constant -> data 1,2,3,4 (last on 4), valid low 2 cycles, then 5,6,7,8 (last on 8).
REQ-028 mode 0, ready toggling 1,0,1,0 -> data/valid stable while ready=0; sequence 1..8 with no duplicates or skips; last on 4 and 8; beat_cnt=8.
REQ-029 mode 2 -> 1,2,3,4 then done=1, valid=0; en=0 -> done=0, IDLE; en=1 again -> 5,6,7,8.
REQ-030 DATA_W=4, mode 0, ready=1 -> payload 1..15, 0, 1 (wrap); last every 4th beat.
REQ-031 en dropped while valid=1 and ready=0 for 3 cycles -> valid held 3 cycles, clears after transfer; restart pulse during SEND at data=6 -> beat 6 completes, next beat data=1.
REQ-032 rst_n pulsed low mid-burst with ready=0 -> valid=0, data=0, beat_cnt=0 immediately; after release and en=1 -> data restarts at 1.
